// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: three-stage IEEE-754 binary32 multiplier (RNE) with valid/ready at both ends.
// Define FP_MUL_SPECIALS_EN for inf/NaN handling and overflow to inf; otherwise overflow saturates.
module fp32_mul_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_prod,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd48;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // m holds bits [46:0] of the aligned significand; the packed add lets a mantissa carry bump the exponent
  function automatic logic [32:0] round_rne(input logic [9:0] exp_f, input logic [46:0] m,
                                            input logic sticky_in);
    logic g, r, s, inc;
    g   = m[23];
    r   = m[22];
    s   = (|m[21:0]) | sticky_in;
    inc = g & (r | s | m[24]);
    return {exp_f, m[46:24]} + 33'(inc);
  endfunction

  function automatic logic [31:0] pack_ovf(input logic s, input logic [32:0] rnd);
    logic [31:0] r;
    r = {s, rnd[30:0]};
    if (rnd[32:23] >= 10'd255) begin
`ifdef FP_MUL_SPECIALS_EN
      r = {s, 8'hFF, 23'h0};
`else
      r = {s, 31'h7F7FFFFF};
`endif
    end
    return r;
  endfunction

  logic adv;

  logic                    vld_p1_q, vld_p2_q, vld_p3_q;
  logic                    sign_p1_q, sign_p2_q;
  logic [7:0]              ea_p1_q, eb_p1_q;
  logic [23:0]             ma_p1_q, mb_p1_q;
  logic [TAG_W-1:0]        tag_p1_q, tag_p2_q, tag_p3_q;
  logic [47:0]             prod_p2_q;
  logic signed [9:0]       exp_p2_q;
  logic [31:0]             prod_p3_q;

  logic                    sign_d;
  logic [7:0]              ea_d, eb_d;
  logic [23:0]             ma_d, mb_d;
  logic signed [9:0]       exp_d;
  logic [31:0]             prod_d;

`ifdef FP_MUL_SPECIALS_EN
  logic nan_p1_q, inf_p1_q, nan_p2_q, inf_p2_q;
  logic nan_d, inf_d;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
`endif

  assign adv       = !vld_p3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p3_q;
  assign out_prod  = prod_p3_q;
  assign out_tag   = tag_p3_q;

  // S1: unpack operands, fold subnormals into exponent 1 with hidden bit 0
  always_comb begin
    sign_d = in_a[31] ^ in_b[31];
    ea_d   = (in_a[30:23] == 8'd0) ? 8'd1 : in_a[30:23];
    eb_d   = (in_b[30:23] == 8'd0) ? 8'd1 : in_b[30:23];
    ma_d   = {(in_a[30:23] != 8'd0), in_a[22:0]};
    mb_d   = {(in_b[30:23] != 8'd0), in_b[22:0]};
`ifdef FP_MUL_SPECIALS_EN
    a_zero = (in_a[30:0] == 31'd0);
    b_zero = (in_b[30:0] == 31'd0);
    a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf_d  = (a_inf | b_inf) & ~nan_d;
`endif
  end

  // S2: significand product and biased exponent sum
  assign exp_d = $signed({2'b00, ea_p1_q}) + $signed({2'b00, eb_p1_q}) - 10'sd127;

  // S3: normalize (left towards bit 47 or right into subnormal range), then round
  logic [5:0]         lz, lsh, rsh_c;
  logic signed [11:0] e_norm, headroom, lz_s, rsh;
  logic [9:0]         e_adj, exp_f;
  logic [95:0]        ext;
  logic [47:0]        m_norm;
  logic               sticky;
  logic [32:0]        rnd;

  always_comb begin
    lz       = lzc48(prod_p2_q);
    e_norm   = {{2{exp_p2_q[9]}}, exp_p2_q} + 12'sd1;
    headroom = e_norm - 12'sd1;
    lz_s     = signed'({6'b0, lz});
    lsh      = 6'd0;
    rsh      = 12'sd0;
    rsh_c    = 6'd0;
    e_adj    = 10'd0;
    ext      = '0;
    m_norm   = prod_p2_q;
    sticky   = 1'b0;
    exp_f    = 10'd0;
    if (e_norm >= 12'sd1) begin
      lsh    = (headroom > lz_s) ? lz : 6'(headroom);
      m_norm = prod_p2_q << lsh;
      e_adj  = 10'(e_norm - signed'({6'b0, lsh}));
      exp_f  = m_norm[47] ? e_adj : 10'd0;
    end else begin
      rsh    = 12'sd1 - e_norm;
      rsh_c  = (rsh > 12'sd48) ? 6'd48 : 6'(rsh);
      ext    = {prod_p2_q, 48'b0} >> rsh_c;
      m_norm = ext[95:48];
      sticky = |ext[47:0];
    end
    rnd    = round_rne(exp_f, m_norm[46:0], sticky);
    prod_d = pack_ovf(sign_p2_q, rnd);
`ifdef FP_MUL_SPECIALS_EN
    if (nan_p2_q)      prod_d = 32'h7FC00000;
    else if (inf_p2_q) prod_d = {sign_p2_q, 8'hFF, 23'h0};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      prod_p3_q <= 32'h0;
      tag_p3_q  <= '0;
    end else if (adv) begin
      vld_p1_q  <= in_valid;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      prod_p3_q <= prod_d;
      tag_p3_q  <= tag_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1_q <= sign_d;
      ea_p1_q   <= ea_d;
      eb_p1_q   <= eb_d;
      ma_p1_q   <= ma_d;
      mb_p1_q   <= mb_d;
      tag_p1_q  <= in_tag;
      sign_p2_q <= sign_p1_q;
      prod_p2_q <= ma_p1_q * mb_p1_q;
      exp_p2_q  <= exp_d;
      tag_p2_q  <= tag_p1_q;
`ifdef FP_MUL_SPECIALS_EN
      nan_p1_q  <= nan_d;
      inf_p1_q  <= inf_d;
      nan_p2_q  <= nan_p1_q;
      inf_p2_q  <= inf_p1_q;
`endif
    end
  end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Scoreboard bench for fp32_mul_pipe: reference products from exact integer significand arithmetic.
module tb_fp32_mul_pipe;
  localparam int TAG_W = 4;

  logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_a, in_b, out_prod;
  logic [TAG_W-1:0] in_tag, out_tag;

  fp32_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [31:0]      prod;
    logic [TAG_W-1:0] tag;
    logic [31:0]      cyc;
    logic             lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, out_cnt = 0;
  logic [31:0] cyc = 0;
  logic        rand_bp, lat_chk, ovr_en;
  logic [31:0] ovr_val;
  logic        held = 0;
  logic [31:0] hold_prod;
  logic [TAG_W-1:0] hold_tag;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: value = M * 2^X per operand; product rounded to the binary32 quantum, ties to even.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, x, p, q, sh, field;
    longint unsigned ma, mb, P, keep, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FP_MUL_SPECIALS_EN
    begin
      logic an, bn, ai, bi, az, bz;
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      az = (a[30:0] == 0);
      bz = (b[30:0] == 0);
      if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
      if (ai || bi) return {s, 8'hFF, 23'h0};
    end
`endif
    ma = (ea == 0) ? 64'(a[22:0]) : (64'(a[22:0]) | 64'h800000);
    mb = (eb == 0) ? 64'(b[22:0]) : (64'(b[22:0]) | 64'h800000);
    x  = ((ea == 0) ? 1 : ea) - 150 + ((eb == 0) ? 1 : eb) - 150;
    P  = ma * mb;
    if (P == 0) return {s, 31'h0};
    p = 63;
    while (!P[p]) p--;
    q = p + x - 23;
    if (q < -149) q = -149;
    if (q > x) begin
      sh = q - x;
      if (sh > 60) keep = 0;
      else begin
        keep = P >> sh;
        rem  = P & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
      end
    end else keep = P << (x - q);
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      q++;
    end
    if (keep < (64'd1 << 23)) return {s, 8'h0, keep[22:0]};
    field = q + 150;
`ifdef FP_MUL_SPECIALS_EN
    if (field >= 255) return {s, 8'hFF, 23'h0};
`else
    if (field >= 255) return {s, 31'h7F7FFFFF};
`endif
    return {s, 8'(field), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:0]  = 31'h0;
      2: r[30:23] = 8'hFF;
      3: r[11:0]  = 12'h0;
      4, 5, 6: r[30:23] = 8'($urandom_range(100, 154));
      7: r[30:23] = 8'($urandom_range(1, 40));
      8: r[30:23] = 8'($urandom_range(200, 254));
      default: ;
    endcase
    return r;
  endfunction

  // Expectation pushed when a transfer is about to happen at the next rising edge.
  always @(negedge clk) begin : push_blk
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e.prod = ovr_en ? ovr_val : ref_mul(in_a, in_b);
      e.tag  = in_tag;
      e.cyc  = cyc;
      e.lat  = lat_chk;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (!rst_n) held = 0;
    else begin
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_prod", 64'(out_prod), 64'(hold_prod));
        check("hold_tag", 64'(out_tag), 64'(hold_tag));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
      held      = out_valid && !out_ready;
      hold_prod = out_prod;
      hold_tag  = out_tag;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got prod %h tag %h, required no output", out_prod, out_tag);
        end else begin
          e = sb.pop_front();
          check("prod", 64'(out_prod), 64'(e.prod));
          check("tag", 64'(out_tag), 64'(e.tag));
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    int guard = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                          input logic [31:0] req);
    ovr_en = 1; ovr_val = req; lat_chk = 1;
    send(a, b, t);
    ovr_en = 0; lat_chk = 0; in_valid = 0;
  endtask

  task automatic drain();
    int g = 0;
    in_valid = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    clk = 0; rst_n = 1; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0;
    out_ready = 1; rand_bp = 0; lat_chk = 0; ovr_en = 0; ovr_val = 0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1;
    @(posedge clk); #1;

    directed(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000);
    directed(32'h3F800001, 32'h3F800001, 4'd1, 32'h3F800002);
    directed(32'h00800000, 32'h3F000000, 4'd2, 32'h00400000);
    directed(32'h00000001, 32'h40000000, 4'd3, 32'h00000002);
    directed(32'hC0000000, 32'h3F800000, 4'd4, 32'hC0000000);
    directed(32'h80000000, 32'h3F800000, 4'd6, 32'h80000000);
`ifdef FP_MUL_SPECIALS_EN
    directed(32'h7F000000, 32'h40000000, 4'd7, 32'h7F800000);
    directed(32'h7F800000, 32'h00000000, 4'd8, 32'h7FC00000);
`else
    directed(32'h7F000000, 32'h40000000, 4'd7, 32'h7F7FFFFF);
`endif
    drain();

    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'h3F800000 + (32'(i) << 20), 32'h40000000, 4'(i));
        in_valid = 0;
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 20) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1;
        out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("bp_count", 64'(out_cnt - base), 64'd8);

    rand_bp = 1;
    for (int n = 0; n < 400; n++) begin
      send(rand_op(), rand_op(), 4'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
    end
    rand_bp = 0; out_ready = 1;
    drain();

    send(32'h3F800000, 32'h40400000, 4'd9);
    send(32'h40000000, 32'h40000000, 4'd10);
    send(32'h40400000, 32'h40400000, 4'd11);
    in_valid = 0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_prod", 64'(out_prod), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    directed(32'h40800000, 32'h3E800000, 4'd12, 32'h3F800000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
